output_stream_if: RTL
=====================

Name: output_stream_if

Overview:
- Downstream neighbour of the FFT output buffer. Consumes its registered DATA_BUS stream plus the frame-end `last` flag, and drives its `is_ready` pop request.
- Read latency through the output buffer is fixed at LATENCY cycles, so `is_ready` is credit-based. A small show-ahead FIFO absorbs in-flight beats, and the block presents an AXI-Stream-style master to the chip output interface.
- Also checks frame length against the configured point size and counts delivered frames.

Parameters:
DEPTH, 8, FIFO entries; must be >= LATENCY+2 for full throughput.
LATENCY, 2, cycles from is_ready high to the corresponding data_in.valid.
CNT_W, 16, width of frame_count.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
data_in  input  DATA_BUS  {valid, data[31:0]}; data = {data_i[31:16], data_r[15:0]}
last_in  input  1  frame-end flag, aligned with data_in.valid
is_ready  output  1  pop request to the output buffer
point  input  4  log2 FFT size (1..9); any other value disables frame checking
m_tdata  output  32  stream data (FIFO head)
m_tvalid  output  1  stream valid
m_tlast  output  1  stream frame end
m_tready  input  1  stream ready from the output interface
frame_count  output  CNT_W  frames delivered (tlast handshakes), wraps
overflow_err  output  1  sticky: beat dropped because the FIFO was full
frame_err  output  1  sticky: last_in position mismatched 2^point
err_clr  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers and count = 0; hist = 0.
  - frame_count = 0; beat_cnt = 0; overflow_err = 0; frame_err = 0.
  - Outputs during reset: m_tvalid = 0, m_tlast = 0, m_tdata = 0, is_ready = 0.
  - First cycle after release: is_ready = 1.
- Credit and is_ready:
  - hist is a LATENCY-bit shift register; hist[0] = is_ready of the previous cycle.
  - pending = popcount(hist).
  - is_ready = (count + pending < DEPTH).
  - is_ready is derived only from registers; there is no combinational path from m_tready or data_in.
  - Pops in the current cycle are not credited until the next cycle.
- FIFO push:
  - Push when data_in.valid = 1. Each entry stores {data, last_in}.
  - Beat is accepted if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the beat is dropped and overflow_err is set. This cannot occur when the upstream honours is_ready.
- FIFO output and pop:
  - Show-ahead FIFO: m_tvalid = (count != 0); m_tdata and m_tlast are driven from mem[rd_ptr].
  - Pop occurs on m_tvalid & m_tready.
  - Pointers wrap modulo DEPTH. count changes by push − pop, so a simultaneous push and pop leaves it unchanged.
- Latency: a beat with data_in.valid in cycle t appears on m_tvalid in cycle t+1 when the FIFO is empty.
- Stream rule: once m_tvalid = 1, m_tdata and m_tlast hold until the handshake completes.
- Frame check:
  - Active only when point is in 1..9; N = 2^point.
  - beat_cnt increments on each accepted push, including beats that set overflow_err.
  - When beat_cnt == N−1, last_in must be 1; beat_cnt then returns to 0.
  - If last_in = 1 at any other beat_cnt, or last_in = 0 at N−1: set frame_err and resynchronise beat_cnt to 0.
  - If point is out of range: beat_cnt holds at 0 and no errors are raised.
- frame_count: increments on a handshake with m_tlast = 1, wrapping at 2^CNT_W.
- Sticky flags:
  - err_clr clears both flags.
  - A new error in the same cycle as err_clr wins, and the flag stays set.
- Mid-operation reset: FIFO contents are discarded and no partial frame is emitted afterwards. The upstream shares rst_n, so no stale in-flight beats arrive.

Test Plan:
1. point=3, m_tready held 1, upstream streams 8 beats at full rate, last on beat 8 → 8 stream beats in order, m_tlast only on the 8th, frame_count=1, is_ready never drops, no errors.
2. point=4, m_tready=0 throughout → is_ready deasserts once count+pending reaches 8. Exactly 8 beats are stored, m_tvalid=1 on beat 0, overflow_err stays 0. Then raise m_tready → all 16 beats delivered, frame_count=1.
3. Back-to-back frames with point=9 and m_tready toggled at random 50% → 1024 beats bit-exact against the reference, frame_count=2, no errors.
4. point=2 with last_in injected on beat 3 → frame_err=1 after that cycle, beat_cnt resynchronises, and the next correct 4-beat frame raises no new error. err_clr clears frame_err to 0.
5. Force data_in.valid while the FIFO is full with m_tready=0 → beat dropped, overflow_err=1, and the FIFO contents are unchanged.
6. Assert rst_n=0 mid-frame with 5 beats buffered → m_tvalid=0 and is_ready=0 immediately (asynchronous). After release: is_ready=1, frame_count=0, and nothing is emitted until new input arrives.

Source files
------------

// File: rtl/output_stream_if_if.sv
// Bundle of the upstream (output buffer) side and the downstream AXI-Stream
// side of output_stream_if.
//   data_in  : {valid, data[31:0]} from the output buffer, data = {im, re}
//   last_in  : frame-end flag aligned with data_in.valid
//   is_ready : pop request back to the output buffer
//   m_tdata / m_tvalid / m_tlast / m_tready : AXI-Stream style master channel
// Modport master is the view of the block that owns the stream (the DUT);
// slave is the view of whatever surrounds it.
interface output_stream_if_if;
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } data_bus_t;

  data_bus_t   data_in;
  logic        last_in;
  logic        is_ready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  modport master (
    input  data_in, last_in, m_tready,
    output is_ready, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output data_in, last_in, m_tready,
    input  is_ready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/output_stream_if.sv
// Downstream neighbour of the FFT output buffer. Pops the buffer with a
// credit-based is_ready (fixed LATENCY read pipe), absorbs in-flight beats in a
// show-ahead FIFO and presents them as an AXI-Stream style master. Also checks
// that last_in lands every 2^point beats and counts delivered frames.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : upstream data_in/last_in/is_ready and m_t* stream channel
//   point        : log2 FFT size, 1..9 enables the frame check
//   frame_count  : tlast handshakes seen, wraps
//   overflow_err : sticky, a beat arrived while the FIFO was full
//   frame_err    : sticky, last_in position disagreed with 2^point
//   err_clr      : synchronous clear of both sticky flags
module output_stream_if #(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output_stream_if_if.master   bus,
  input  logic [3:0]           point,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 overflow_err,
  output logic                 frame_err,
  input  logic                 err_clr
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_B  = $clog2(DEPTH + 1);
  localparam int PEND_W = $clog2(LATENCY + 1);
  localparam int SUM_W  = $clog2(DEPTH + LATENCY + 1);

  // Each entry is {data, last}.
  logic [32:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_B-1:0]   count_reg, count_next;
  logic [LATENCY-1:0] hist_reg;
  logic               run_reg;
  logic [9:0]         beat_cnt_reg, beat_cnt_next;
  logic [CNT_W-1:0]   frame_count_reg;
  logic               overflow_err_reg, frame_err_reg;

  logic               pop, push, drop, frame_bad;
  logic [PEND_W-1:0]  pending;
  logic [SUM_W-1:0]   credit_sum;
  logic [32:0]        head;
  logic               point_ok;
  logic [9:0]         last_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Beats already requested but not yet arrived.
  always_comb begin
    pending = '0;
    for (int i = 0; i < LATENCY; i++) begin
      pending = pending + PEND_W'(hist_reg[i]);
    end
  end

  // Registers only: stored beats plus outstanding requests must stay below
  // DEPTH. run_reg keeps is_ready low while in reset and until the first
  // clock edge after release.
  always_comb begin
    credit_sum   = SUM_W'(count_reg) + SUM_W'(pending);
    bus.is_ready = run_reg & (credit_sum < SUM_W'(DEPTH));
  end

  // Show-ahead head of the FIFO; data is zeroed while empty so nothing stale
  // shows after a reset.
  always_comb begin
    head         = mem[rd_ptr_reg];
    bus.m_tvalid = (count_reg != '0);
    bus.m_tdata  = bus.m_tvalid ? head[32:1] : 32'd0;
    bus.m_tlast  = bus.m_tvalid & head[0];
  end

  always_comb begin
    pop  = bus.m_tvalid & bus.m_tready;
    push = bus.data_in.valid & ((count_reg < CNT_B'(DEPTH)) | pop);
    drop = bus.data_in.valid & ~push;
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_B'(1);
      2'b01:   count_next = count_reg - CNT_B'(1);
      default: count_next = count_reg;
    endcase
  end

  // Frame check counts every arriving beat, dropped ones included, so the
  // frame position stays aligned with the upstream even after an overflow.
  always_comb begin
    point_ok      = (point >= 4'd1) && (point <= 4'd9);
    last_idx      = (10'd1 << point) - 10'd1;
    beat_cnt_next = beat_cnt_reg;
    frame_bad     = 1'b0;
    if (!point_ok) begin
      beat_cnt_next = '0;
    end else if (bus.data_in.valid) begin
      if (beat_cnt_reg == last_idx) begin
        beat_cnt_next = '0;
        frame_bad     = ~bus.last_in;
      end else if (bus.last_in) begin
        beat_cnt_next = '0;
        frame_bad     = 1'b1;
      end else begin
        beat_cnt_next = beat_cnt_reg + 10'd1;
      end
    end
  end

  // Storage has no reset; count gating on the outputs hides old contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.data_in.data, bus.last_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      hist_reg         <= '0;
      run_reg          <= 1'b0;
      beat_cnt_reg     <= '0;
      frame_count_reg  <= '0;
      overflow_err_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      run_reg   <= 1'b1;
      count_reg <= count_next;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      for (int i = LATENCY - 1; i > 0; i--) begin
        hist_reg[i] <= hist_reg[i-1];
      end
      hist_reg[0]  <= bus.is_ready;
      beat_cnt_reg <= beat_cnt_next;
      if (pop && bus.m_tlast) frame_count_reg <= frame_count_reg + CNT_W'(1);
      // A new error in the clearing cycle still sets the flag.
      overflow_err_reg <= (overflow_err_reg & ~err_clr) | drop;
      frame_err_reg    <= (frame_err_reg & ~err_clr) | frame_bad;
    end
  end

  assign frame_count  = frame_count_reg;
  assign overflow_err = overflow_err_reg;
  assign frame_err    = frame_err_reg;
endmodule
